chase_mode_ctrl: RTL and testbench



---
 rtl/chase_pkg.sv | 26 ++
 rtl/debounce_bit.sv | 40 ++++
 rtl/chase_mode_ctrl.sv | 113 +++++++++++
 tb/tb_chase_mode_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/chase_pkg.sv
// rtl/chase_pkg.sv - shared mode constants, FSM encoding and defaults for the chaser control path
package chase_pkg;

  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_R2L  = 2'b01;
  localparam logic [1:0] MODE_L2R  = 2'b10;
  localparam logic [1:0] MODE_BNC  = 2'b11;

  localparam int DEB_CYCLES_DEF = 500000;
  localparam int BASE_DIV_DEF   = 1562500;

  typedef enum logic [1:0] {
    ST_STOP   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_RUN    = 2'b10
  } state_t;

  // Lowest switch wins: SW0 > SW1 > SW2.
  function automatic logic [1:0] decode_mode(input logic [2:0] sw);
    if (sw[0])      return MODE_R2L;
    else if (sw[1]) return MODE_L2R;
    else if (sw[2]) return MODE_BNC;
    else            return MODE_STOP;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser followed by a consecutive-cycle debouncer
module debounce_bit
  import chase_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync0;
  logic          sync1;
  logic [CW-1:0] cnt;

  // Any cycle where the synchronised input agrees with the stable value restarts the count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      if (sync1 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        stable <= sync1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/chase_mode_ctrl.sv
// rtl/chase_mode_ctrl.sv - debounced mode/speed decode with step and restart pulse generation
module chase_mode_ctrl
  import chase_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int BASE_DIV   = BASE_DIV_DEF
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [17:0] SW,
  output logic [1:0]  mode,
  output logic        step,
  output logic        restart,
  output logic [2:0]  speed
);

  localparam int PW = $clog2(BASE_DIV);

  logic [5:0] raw;
  logic [5:0] stable;
  logic       unused_sw;

  assign raw       = {SW[17:15], SW[2:0]};
  assign unused_sw = ^SW[14:3];

  for (genvar i = 0; i < 6; i++) begin : g_deb
    debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (Clock),
      .resetn (Resetn),
      .raw    (raw[i]),
      .stable (stable[i])
    );
  end

  assign speed = stable[5:3];

  logic [1:0]    dec;
  state_t        state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [2:0]    ival, ival_n;
  logic          step_n, restart_n;
  logic          base_tick;
  logic [3:0]    thr;

  assign dec       = decode_mode(stable[2:0]);
  assign base_tick = (pre == PW'(BASE_DIV - 1));
  assign thr       = 4'd8 - {1'b0, speed};

  // A mode change always wins over a step that happens to be due in the same cycle.
  always_comb begin
    state_n   = state;
    pre_n     = '0;
    ival_n    = '0;
    step_n    = 1'b0;
    restart_n = 1'b0;
    unique case (state)
      ST_STOP: begin
        if (dec != MODE_STOP) begin
          state_n   = ST_SETTLE;
          restart_n = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (dec != mode) begin
          restart_n = 1'b1;
          state_n   = (dec == MODE_STOP) ? ST_STOP : ST_SETTLE;
        end else if (base_tick) begin
          state_n = ST_RUN;
        end else begin
          pre_n = pre + 1'b1;
        end
      end
      ST_RUN: begin
        if (dec != mode) begin
          restart_n = 1'b1;
          state_n   = (dec == MODE_STOP) ? ST_STOP : ST_SETTLE;
        end else begin
          pre_n  = base_tick ? '0 : pre + 1'b1;
          ival_n = ival;
          if (base_tick) begin
            // >= so that a speed-up past the current count fires on this tick.
            if (({1'b0, ival} + 4'd1) >= thr) begin
              step_n = 1'b1;
              ival_n = '0;
            end else begin
              ival_n = ival + 1'b1;
            end
          end
        end
      end
      default: state_n = ST_STOP;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state   <= ST_STOP;
      pre     <= '0;
      ival    <= '0;
      mode    <= MODE_STOP;
      step    <= 1'b0;
      restart <= 1'b0;
    end else begin
      state   <= state_n;
      pre     <= pre_n;
      ival    <= ival_n;
      mode    <= dec;
      step    <= step_n;
      restart <= restart_n;
    end
  end

endmodule

// File: tb/tb_chase_mode_ctrl.sv
// tb/tb_chase_mode_ctrl.sv - directed and randomized checks of chase_mode_ctrl against a timeline model
module tb_chase_mode_ctrl;

  localparam int DEB = 4;
  localparam int B   = 8;

  logic        Clock  = 1'b0;
  logic        Resetn = 1'b0;
  logic [17:0] SW     = '0;
  logic [1:0]  mode;
  logic        step;
  logic        restart;
  logic [2:0]  speed;

  chase_mode_ctrl #(.DEB_CYCLES(DEB), .BASE_DIV(B)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .SW      (SW),
    .mode    (mode),
    .step    (step),
    .restart (restart),
    .speed   (speed)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: switch history window for debouncing, and elapsed time since the last
  // restart to place base ticks; RUN is implied by a non-stop mode.
  logic [5:0] hq[$];
  logic [5:0] m_stable;
  logic [1:0] m_mode;
  logic       m_step, m_restart;
  longint     cyc = 0;
  longint     start;
  int         ticks;

  function automatic logic [1:0] ref_decode(input logic [2:0] s);
    if (s[0]) return 2'b01;
    if (s[1]) return 2'b10;
    if (s[2]) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_edge();
    logic [5:0] cur, nstable;
    logic [1:0] dec;
    longint     el;
    bit         all_diff;
    cyc++;
    if (!Resetn) begin
      hq.delete();
      repeat (DEB + 2) hq.push_back(6'b0);
      m_stable  = '0;
      m_mode    = 2'b00;
      m_step    = 1'b0;
      m_restart = 1'b0;
      start     = 0;
      ticks     = 0;
      return;
    end
    cur     = {SW[17:15], SW[2:0]};
    nstable = m_stable;
    for (int b = 0; b < 6; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (hq[hq.size() - 2 - j][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) nstable[b] = ~m_stable[b];
    end
    hq.push_back(cur);
    void'(hq.pop_front());

    dec       = ref_decode(m_stable[2:0]);
    m_step    = 1'b0;
    m_restart = 1'b0;
    if (dec != m_mode) begin
      m_restart = 1'b1;
      m_mode    = dec;
      start     = cyc;
      ticks     = 0;
    end else if (m_mode != 2'b00) begin
      el = cyc - start;
      if (el >= 2 * B && (el % B) == 0) begin
        ticks++;
        if (ticks >= 8 - int'(m_stable[5:3])) begin
          m_step = 1'b1;
          ticks  = 0;
        end
      end
    end
    m_stable = nstable;
  endtask

  always @(posedge Clock) begin
    model_edge();
    #1;
    chk("mode", mode, m_mode);
    chk("step", step, m_step);
    chk("restart", restart, m_restart);
    chk("speed", speed, m_stable[5:3]);
    chk("step_and_restart", int'(step & restart), 0);
  end

  task automatic wait_pulse(input string name, input bit on_step, input int budget, output int k);
    k = 0;
    while (k < budget) begin
      @(negedge Clock);
      k++;
      if (on_step ? step : restart) return;
    end
    chk({name, "_timeout"}, k, -1);
    k = -1;
  endtask

  task automatic count_pulses(input bit on_step, input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge Clock);
      if (on_step ? step : restart) c++;
    end
  endtask

  function automatic logic [17:0] sw_of(input logic [2:0] spd, input logic [2:0] md);
    return {spd, 12'h000, md};
  endfunction

  initial begin
    int k, c;
    logic [17:0] saved;

    Resetn = 1'b0;
    SW     = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("reset_outputs", int'({mode, step, restart, speed}), 0);
    end
    Resetn = 1'b1;
    wait_pulse("first_restart", 1'b0, 20, k);
    chk("first_restart_latency", k, 7);
    chk("first_mode", mode, 1);

    SW = '0;
    wait_pulse("stop_restart", 1'b0, 20, k);
    chk("stop_mode", mode, 0);
    repeat (10) @(negedge Clock);
    SW = 18'h1;
    repeat (3) @(negedge Clock);
    SW = '0;
    count_pulses(1'b0, 20, c);
    chk("glitch_restarts", c, 0);
    chk("glitch_mode", mode, 0);
    SW = 18'h1;
    repeat (4) @(negedge Clock);
    SW = '0;
    count_pulses(1'b0, 30, c);
    chk("accepted_pulse_restarts", c, 2);

    SW = sw_of(3'b111, 3'b001);
    wait_pulse("s7_restart", 1'b0, 20, k);
    wait_pulse("s7_first_step", 1'b1, 40, k);
    chk("s7_settle_to_step", k, 16);
    wait_pulse("s7_step", 1'b1, 40, k);
    chk("s7_period", k, 8);

    SW = sw_of(3'b000, 3'b001);
    repeat (20) @(negedge Clock);
    wait_pulse("s0_step_a", 1'b1, 100, k);
    wait_pulse("s0_step_b", 1'b1, 100, k);
    chk("s0_period", k, 64);

    SW = sw_of(3'b111, 3'b001);
    repeat (30) @(negedge Clock);
    wait_pulse("pre_collide_step", 1'b1, 20, k);
    @(negedge Clock);
    SW = sw_of(3'b111, 3'b010);
    wait_pulse("collide_restart", 1'b0, 20, k);
    chk("collide_latency", k, 7);
    chk("collide_step_low", step, 0);
    chk("collide_mode", mode, 2);
    wait_pulse("post_collide_step", 1'b1, 40, k);
    chk("post_collide_gap", k, 16);

    SW = sw_of(3'b111, 3'b110);
    count_pulses(1'b0, 20, c);
    chk("prio_no_restart", c, 0);
    chk("prio_mode", mode, 2);
    SW = sw_of(3'b111, 3'b100);
    wait_pulse("bounce_restart", 1'b0, 20, k);
    chk("bounce_mode", mode, 3);
    count_pulses(1'b0, 20, c);
    chk("bounce_single_restart", c, 0);

    SW = sw_of(3'b111, 3'b000);
    wait_pulse("drop_restart", 1'b0, 20, k);
    chk("drop_mode", mode, 0);
    count_pulses(1'b1, 200, c);
    chk("drop_no_steps", c, 0);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        Resetn = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge Clock);
        Resetn = 1'b1;
      end
      case ($urandom_range(0, 3))
        0: SW = 18'($urandom);
        1, 2: SW[17:15] = 3'($urandom);
        default: begin
          saved = SW;
          SW[$urandom_range(0, 2)] ^= 1'b1;
          repeat ($urandom_range(1, 5)) @(negedge Clock);
          SW = saved;
        end
      endcase
      repeat ($urandom_range(1, 60)) @(negedge Clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
